pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 11 +
 rtl/pipe_stage_reg_if.sv | 26 ++
 rtl/pipe_payload_reg.sv | 14 +
 rtl/pipe_stage_reg.sv | 49 ++++
 tb/tb_pipe_stage_reg.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default field widths for the pipeline stage register
package pipe_pkg;
  localparam int CTRL_W = 17;
  localparam int REG_W  = 4;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream/downstream beat handshake, flush and occupancy of one stage
interface pipe_stage_reg_if #(
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int REG_W  = pipe_pkg::REG_W,
  parameter int DATA_W = pipe_pkg::DATA_W
);
  logic              flush;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [REG_W-1:0]  in_ra, in_rb, out_ra, out_rb;
  logic [DATA_W-1:0] in_dat_a, in_dat_b, in_off21, in_off_store, in_robj, in_imm;
  logic [DATA_W-1:0] out_dat_a, out_dat_b, out_off21, out_off_store, out_robj, out_imm;
  logic [1:0]        occ;
  modport master (
    output flush, in_valid, in_ctrl, in_ra, in_rb, in_dat_a, in_dat_b, in_off21,
           in_off_store, in_robj, in_imm, out_ready,
    input  in_ready, out_valid, out_ctrl, out_ra, out_rb, out_dat_a, out_dat_b,
           out_off21, out_off_store, out_robj, out_imm, occ
  );
  modport slave (
    input  flush, in_valid, in_ctrl, in_ra, in_rb, in_dat_a, in_dat_b, in_off21,
           in_off_store, in_robj, in_imm, out_ready,
    output in_ready, out_valid, out_ctrl, out_ra, out_rb, out_dat_a, out_dat_b,
           out_off21, out_off_store, out_robj, out_imm, occ
  );
endinterface

// File: rtl/pipe_payload_reg.sv
// pipe_payload_reg: enable register with asynchronous active-low clear
module pipe_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid-buffered pipeline register with flush and occupancy count
module pipe_stage_reg #(
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int REG_W  = pipe_pkg::REG_W,
  parameter int DATA_W = pipe_pkg::DATA_W
) (
  input logic             clk,
  input logic             rst_n,
  pipe_stage_reg_if.slave bus
);
  import pipe_pkg::*;
  localparam int PW = CTRL_W + 2*REG_W + 6*DATA_W;
  state_t            state, state_nx;
  logic [PW-1:0]     in_pay, main_d, main_q, skid_q;
  logic [CTRL_W-1:0] main_ctrl;
  logic              accept, take, main_en, skid_en;
  assign in_pay = {bus.in_ctrl, bus.in_ra, bus.in_rb, bus.in_dat_a, bus.in_dat_b,
                   bus.in_off21, bus.in_off_store, bus.in_robj, bus.in_imm};
  // ready comes only from the registered state so out_ready never reaches in_ready
  assign bus.in_ready  = state != TWO;
  assign bus.out_valid = state != EMPTY;
  assign bus.occ       = state;
  assign accept = bus.in_valid & bus.in_ready;
  assign take   = bus.out_valid & bus.out_ready;
  assign main_en = !bus.flush && ((state == EMPTY && accept) ||
                                  (state == ONE && accept && take) ||
                                  (state == TWO && take));
  assign skid_en = !bus.flush && state == ONE && accept && !take;
  assign main_d  = state == TWO ? skid_q : in_pay;
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   state_nx = accept ? ONE : EMPTY;
      ONE:     state_nx = accept && !take ? TWO : !accept && take ? EMPTY : ONE;
      TWO:     state_nx = take ? ONE : TWO;
      default: state_nx = EMPTY;
    endcase
    if (bus.flush) state_nx = EMPTY;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else state <= state_nx;
  pipe_payload_reg #(.W(PW)) u_main (.clk(clk), .rst_n(rst_n), .en(main_en), .d(main_d), .q(main_q));
  pipe_payload_reg #(.W(PW)) u_skid (.clk(clk), .rst_n(rst_n), .en(skid_en), .d(in_pay), .q(skid_q));
  // bubbles carry a zero control word; the rest of the payload keeps its last value
  assign {main_ctrl, bus.out_ra, bus.out_rb, bus.out_dat_a, bus.out_dat_b,
          bus.out_off21, bus.out_off_store, bus.out_robj, bus.out_imm} = main_q;
  assign bus.out_ctrl = bus.out_valid ? main_ctrl : '0;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for a full-width and a narrow build of pipe_stage_reg
module tb_pipe_stage_reg;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  pipe_stage_reg_if #(.CTRL_W(17), .REG_W(4), .DATA_W(32)) b0 ();
  pipe_stage_reg_if #(.CTRL_W(8), .REG_W(4), .DATA_W(16)) b1 ();
  pipe_stage_reg #(.CTRL_W(17), .REG_W(4), .DATA_W(32)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  pipe_stage_reg #(.CTRL_W(8), .REG_W(4), .DATA_W(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  int total = 0, bad = 0;
  logic stall = 0, fin = 0, fin_done = 0, done1 = 0;
  // reference model: an in-order list of expected beats per instance plus the last presented beat
  logic [16:0]  mc [2][4096];
  logic [199:0] mr [2][4096];
  logic [199:0] lr [2];
  int hd [2], tl [2];
  function automatic void chk(int k, string nm, logic [255:0] a, logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, k, a, e);
    end
  endfunction
  task automatic rst_chk(int k, logic ov, logic ir, logic [1:0] oc, logic [16:0] oct, logic [199:0] ore);
    chk(k, "rst_out_valid", 256'(ov), 256'(0));
    chk(k, "rst_in_ready", 256'(ir), 256'(1));
    chk(k, "rst_occ", 256'(oc), 256'(0));
    chk(k, "rst_ctrl", 256'(oct), 256'(0));
    chk(k, "rst_payload", 256'(ore), 256'(0));
    hd[k] = tl[k];
    lr[k] = '0;
  endtask
  task automatic step(int k, logic ov, logic ir, logic [1:0] oc, logic [16:0] oct, logic [199:0] ore,
                      logic iv, logic ordy, logic fl, logic [16:0] ict, logic [199:0] ire);
    int n = tl[k] - hd[k];
    chk(k, "occ", 256'(oc), 256'(n));
    chk(k, "in_ready", 256'(ir), 256'(n < 2));
    chk(k, "out_valid", 256'(ov), 256'(n > 0));
    if (n > 0) begin
      chk(k, "out_ctrl", 256'(oct), 256'(mc[k][hd[k] % 4096]));
      chk(k, "out_payload", 256'(ore), 256'(mr[k][hd[k] % 4096]));
      lr[k] = mr[k][hd[k] % 4096];
    end else begin
      chk(k, "bubble_ctrl", 256'(oct), 256'(0));
      chk(k, "bubble_hold", 256'(ore), 256'(lr[k]));
    end
    if (n > 0 && ordy) hd[k]++;
    if (fl) hd[k] = tl[k];
    else if (iv && n < 2) begin
      mc[k][tl[k] % 4096] = ict;
      mr[k][tl[k] % 4096] = ire;
      tl[k]++;
    end
  endtask
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      rst_chk(0, b0.out_valid, b0.in_ready, b0.occ, b0.out_ctrl,
              {b0.out_ra, b0.out_rb, b0.out_dat_a, b0.out_dat_b, b0.out_off21, b0.out_off_store, b0.out_robj, b0.out_imm});
      rst_chk(1, b1.out_valid, b1.in_ready, b1.occ, 17'(b1.out_ctrl),
              200'({b1.out_ra, b1.out_rb, b1.out_dat_a, b1.out_dat_b, b1.out_off21, b1.out_off_store, b1.out_robj, b1.out_imm}));
    end else begin
      step(0, b0.out_valid, b0.in_ready, b0.occ, b0.out_ctrl,
           {b0.out_ra, b0.out_rb, b0.out_dat_a, b0.out_dat_b, b0.out_off21, b0.out_off_store, b0.out_robj, b0.out_imm},
           b0.in_valid, b0.out_ready, b0.flush, b0.in_ctrl,
           {b0.in_ra, b0.in_rb, b0.in_dat_a, b0.in_dat_b, b0.in_off21, b0.in_off_store, b0.in_robj, b0.in_imm});
      step(1, b1.out_valid, b1.in_ready, b1.occ, 17'(b1.out_ctrl),
           200'({b1.out_ra, b1.out_rb, b1.out_dat_a, b1.out_dat_b, b1.out_off21, b1.out_off_store, b1.out_robj, b1.out_imm}),
           b1.in_valid, b1.out_ready, b1.flush, 17'(b1.in_ctrl),
           200'({b1.in_ra, b1.in_rb, b1.in_dat_a, b1.in_dat_b, b1.in_off21, b1.in_off_store, b1.in_robj, b1.in_imm}));
      if (fin && !fin_done) begin
        chk(0, "drain", 256'(tl[0] - hd[0]), 256'(0));
        chk(1, "drain", 256'(tl[1] - hd[1]), 256'(0));
        chk(0, "stall", 256'(stall), 256'(0));
        fin_done = 1;
      end
    end
  end
  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rnd0();
    b0.in_ra = 4'($urandom);
    b0.in_rb = 4'($urandom);
    b0.in_dat_b = $urandom;
    b0.in_off21 = $urandom;
    b0.in_off_store = $urandom;
    b0.in_robj = $urandom;
    b0.in_imm = $urandom;
  endtask
  task automatic beat(input logic [16:0] c, input logic [31:0] a);
    logic got;
    got = 0;
    b0.in_valid = 1;
    b0.in_ctrl = c;
    b0.in_dat_a = a;
    rnd0();
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = b0.in_ready;
      @(posedge clk);
      #1;
    end
    if (!got) stall = 1;
    b0.in_valid = 0;
  endtask
  initial begin
    logic acc;
    b1.flush = 0; b1.in_valid = 0; b1.out_ready = 0;
    b1.in_ctrl = '0; b1.in_ra = '0; b1.in_rb = '0; b1.in_dat_a = '0; b1.in_dat_b = '0;
    b1.in_off21 = '0; b1.in_off_store = '0; b1.in_robj = '0; b1.in_imm = '0;
    wait (rst_n);
    @(posedge clk);
    #1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = b1.in_valid && b1.in_ready;
      @(posedge clk);
      #1;
      if (acc || !b1.in_valid) begin
        b1.in_valid = 1'($urandom);
        b1.in_ctrl = 8'($urandom); b1.in_ra = 4'($urandom); b1.in_rb = 4'($urandom);
        b1.in_dat_a = 16'($urandom); b1.in_dat_b = 16'($urandom); b1.in_off21 = 16'($urandom);
        b1.in_off_store = 16'($urandom); b1.in_robj = 16'($urandom); b1.in_imm = 16'($urandom);
      end
      b1.out_ready = 1'($urandom);
      b1.flush = $urandom_range(31) == 0;
    end
    b1.in_valid = 0; b1.flush = 0; b1.out_ready = 1;
    done1 = 1;
  end
  initial begin
    b0.flush = 0; b0.in_valid = 0; b0.out_ready = 0;
    b0.in_ctrl = '0; b0.in_dat_a = '0;
    rnd0();
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    idle(1);
    b0.out_ready = 1;
    beat(17'h1ABCD, 32'h12345678);
    idle(3);
    b0.out_ready = 0;
    fork
      begin
        beat(17'h0A, $urandom);
        beat(17'h0B, $urandom);
        beat(17'h0C, $urandom);
      end
      begin
        idle(6);
        b0.out_ready = 1;
      end
    join
    idle(4);
    for (int i = 0; i < 100; i++) beat(17'(i + 1), $urandom);
    idle(3);
    b0.out_ready = 0;
    beat(17'h1000A, $urandom);
    beat(17'h1000B, $urandom);
    b0.in_valid = 1; b0.in_ctrl = 17'h1DEAD; b0.flush = 1;
    idle(1);
    b0.flush = 0; b0.in_valid = 0;
    idle(2);
    beat(17'h1000C, $urandom);
    b0.in_valid = 1; b0.in_ctrl = 17'h1BEEF; b0.flush = 1; b0.out_ready = 1;
    idle(1);
    b0.flush = 0; b0.in_valid = 0;
    idle(3);
    fork
      for (int i = 0; i < 20; i++) beat(17'($urandom), $urandom);
      begin
        idle(6);
        #2 rst_n = 0;
        idle(3);
        #2 rst_n = 1;
      end
      for (int i = 0; i < 12; i++) begin
        b0.out_ready = 1'($urandom);
        idle(1);
      end
    join
    b0.out_ready = 1;
    for (int i = 0; i < 10000 && !done1; i++) idle(1);
    if (!done1) stall = 1;
    idle(5);
    fin = 1;
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
